// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program-counter sequencer: FSM state codes and
// the per-cycle PC update selection.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_STALL = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      SEL_NONE = 3'd0,
      SEL_JMP  = 3'd1,
      SEL_BR   = 3'd2,
      SEL_INC  = 3'd3,
      SEL_HOLD = 3'd4
   } sel_t;

endpackage

// File: rtl/pc_reg.sv
// Program-counter register: loadable WIDTH-bit flop with asynchronous
// active-low reset to the reset vector.
module pc_reg #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = 32'h0040_0000
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n)
         q <= RESET_VEC;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: start/run/stall/halt FSM, jump/branch
// arbitration with registered acks, target alignment and misalign flag.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = 32'h0040_0000,
   parameter int               INC       = 4
) (
   input  logic             CLK,
   input  logic             RST_n,
   input  logic             start,
   input  logic             halt,
   input  logic             stall,
   input  logic             jmp_req,
   input  logic [WIDTH-1:0] jmp_addr,
   input  logic             br_req,
   input  logic [WIDTH-1:0] br_addr,
   output logic             jmp_ack,
   output logic             br_ack,
   output logic [WIDTH-1:0] pc,
   output logic             pc_valid,
   output logic [1:0]       state,
   output logic             misalign
);

   localparam logic [WIDTH-1:0] INC_W    = WIDTH'(INC);
   localparam logic [WIDTH-1:0] LOW_MASK = INC_W - WIDTH'(1);

   state_t           state_q, state_d;
   sel_t             sel;
   logic             restart;
   logic             jmp_ok, br_ok;
   logic             pc_load;
   logic [WIDTH-1:0] pc_d;

   function automatic logic [WIDTH-1:0] align_tgt(input logic [WIDTH-1:0] a);
      return a & ~LOW_MASK;
   endfunction

   function automatic logic off_grid(input logic [WIDTH-1:0] a);
      return |(a & LOW_MASK);
   endfunction

   // A requester seeing its ack this cycle is still dropping req; skip it.
   assign jmp_ok = jmp_req & ~jmp_ack;
   assign br_ok  = br_req & ~br_ack;

   always_comb begin
      state_d = state_q;
      sel     = SEL_NONE;
      restart = 1'b0;
      case (state_q)
         S_IDLE, S_HALT: begin
            if (start) begin
               state_d = S_RUN;
               restart = 1'b1;
            end
         end
         S_RUN: begin
            if (halt)
               state_d = S_HALT;
            else if (jmp_ok)
               sel = SEL_JMP;
            else if (br_ok)
               sel = SEL_BR;
            else if (stall) begin
               state_d = S_STALL;
               sel     = SEL_HOLD;
            end else
               sel = SEL_INC;
         end
         S_STALL: begin
            if (halt)
               state_d = S_HALT;
            else if (!stall)
               state_d = S_RUN;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pc_d    = pc;
      pc_load = 1'b1;
      case (sel)
         SEL_JMP: pc_d = align_tgt(jmp_addr);
         SEL_BR:  pc_d = align_tgt(br_addr);
         SEL_INC: pc_d = pc + INC_W;
         default: pc_load = 1'b0;
      endcase
      if (restart) begin
         pc_d    = RESET_VEC;
         pc_load = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q  <= S_IDLE;
         jmp_ack  <= 1'b0;
         br_ack   <= 1'b0;
         pc_valid <= 1'b0;
         misalign <= 1'b0;
      end else begin
         state_q  <= state_d;
         jmp_ack  <= (sel == SEL_JMP);
         br_ack   <= (sel == SEL_BR);
         pc_valid <= (sel == SEL_JMP) || (sel == SEL_BR) || (sel == SEL_INC);
         if (restart)
            misalign <= 1'b0;
         else if (((sel == SEL_JMP) && off_grid(jmp_addr)) ||
                  ((sel == SEL_BR) && off_grid(br_addr)))
            misalign <= 1'b1;
      end
   end

   pc_reg #(
      .WIDTH     (WIDTH),
      .RESET_VEC (RESET_VEC)
   ) u_pc_reg (
      .CLK   (CLK),
      .RST_n (RST_n),
      .load  (pc_load),
      .d     (pc_d),
      .q     (pc)
   );

   assign state = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, reset-mid-jump sequence,
// and a randomized run against a cycle-level behavioural model.
module tb_pc_sequencer;

   localparam logic [31:0] RV = 32'h0040_0000;
   localparam int P_IDLE = 0, P_RUN = 1, P_STALL = 2, P_HALT = 3;

   logic        CLK = 1'b0;
   logic        RST_n = 1'b0;
   logic        start = 1'b0, halt = 1'b0, stall = 1'b0;
   logic        jmp_req = 1'b0, br_req = 1'b0;
   logic [31:0] jmp_addr = '0, br_addr = '0;
   logic        jmp_ack, br_ack, pc_valid, misalign;
   logic [31:0] pc;
   logic [1:0]  state;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   pc_sequencer dut (
      .CLK      (CLK),
      .RST_n    (RST_n),
      .start    (start),
      .halt     (halt),
      .stall    (stall),
      .jmp_req  (jmp_req),
      .jmp_addr (jmp_addr),
      .br_req   (br_req),
      .br_addr  (br_addr),
      .jmp_ack  (jmp_ack),
      .br_ack   (br_ack),
      .pc       (pc),
      .pc_valid (pc_valid),
      .state    (state),
      .misalign (misalign)
   );

   typedef struct {
      logic        start, halt, stall, jreq;
      logic [31:0] ja;
      logic        breq;
      logic [31:0] ba;
      logic [31:0] pc;
      logic [1:0]  st;
      logic        jack, back, vld, mis;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic s, h, sl, jr, input logic [31:0] ja,
                               input logic br, input logic [31:0] ba,
                               input logic [31:0] p, input logic [1:0] st,
                               input logic jk, bk, v, m);
      vec_t r;
      r.start = s;  r.halt = h;  r.stall = sl; r.jreq = jr; r.ja = ja;
      r.breq = br;  r.ba = ba;   r.pc = p;     r.st = st;
      r.jack = jk;  r.back = bk; r.vld = v;    r.mis = m;
      return r;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
      end
   endtask

   task automatic chk_all(input int idx, input logic [31:0] e_pc, input logic [1:0] e_st,
                          input logic e_jk, e_bk, e_v, e_m);
      chk("pc", idx, pc, e_pc);
      chk("state", idx, 32'(state), 32'(e_st));
      chk("jmp_ack", idx, 32'(jmp_ack), 32'(e_jk));
      chk("br_ack", idx, 32'(br_ack), 32'(e_bk));
      chk("pc_valid", idx, 32'(pc_valid), 32'(e_v));
      chk("misalign", idx, 32'(misalign), 32'(e_m));
   endtask

   // Behavioural reference: one call = one rising edge, inputs as currently driven.
   int          m_ph;
   logic [31:0] m_pc;
   logic        m_jack, m_back, m_vld, m_mis;

   task automatic model_reset();
      m_ph = P_IDLE; m_pc = RV; m_jack = 0; m_back = 0; m_vld = 0; m_mis = 0;
   endtask

   task automatic model_step();
      logic nj, nb, nv;
      nj = 0; nb = 0; nv = 0;
      if (m_ph == P_IDLE || m_ph == P_HALT) begin
         if (start) begin m_ph = P_RUN; m_pc = RV; m_mis = 0; end
      end else if (m_ph == P_STALL) begin
         if (halt) m_ph = P_HALT;
         else if (!stall) m_ph = P_RUN;
      end else begin
         if (halt) m_ph = P_HALT;
         else if (jmp_req && !m_jack) begin
            m_pc = {jmp_addr[31:2], 2'b00};
            if (jmp_addr % 4 != 0) m_mis = 1;
            nj = 1; nv = 1;
         end else if (br_req && !m_back) begin
            m_pc = {br_addr[31:2], 2'b00};
            if (br_addr % 4 != 0) m_mis = 1;
            nb = 1; nv = 1;
         end else if (stall) m_ph = P_STALL;
         else begin m_pc = m_pc + 32'd4; nv = 1; end
      end
      m_jack = nj; m_back = nb; m_vld = nv;
   endtask

   function automatic logic [31:0] rnd_addr();
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      return a;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      tbl.push_back(mk(1,0,0,0,0,0,0, RV,         1,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0, RV+32'h4,   1,0,0,1,0));
      tbl.push_back(mk(0,0,0,0,0,0,0, RV+32'h8,   1,0,0,1,0));
      tbl.push_back(mk(0,0,0,0,0,0,0, RV+32'hC,   1,0,0,1,0));
      tbl.push_back(mk(0,0,0,1,32'h1000,1,32'h2000, 32'h1000, 1,1,0,1,0));
      tbl.push_back(mk(0,0,0,0,32'h1000,1,32'h2000, 32'h2000, 1,0,1,1,0));
      tbl.push_back(mk(0,0,0,0,0,0,0, 32'h2004,   1,0,0,1,0));
      tbl.push_back(mk(0,0,1,0,0,0,0, 32'h2004,   2,0,0,0,0));
      tbl.push_back(mk(0,0,1,0,0,0,0, 32'h2004,   2,0,0,0,0));
      tbl.push_back(mk(0,0,1,0,0,0,0, 32'h2004,   2,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0, 32'h2004,   1,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0, 32'h2008,   1,0,0,1,0));
      tbl.push_back(mk(0,0,0,1,32'h1003,0,0, 32'h1000, 1,1,0,1,1));
      tbl.push_back(mk(0,0,0,0,0,0,0, 32'h1004,   1,0,0,1,1));
      tbl.push_back(mk(0,0,0,1,32'hFFFF_FFFC,0,0, 32'hFFFF_FFFC, 1,1,0,1,1));
      tbl.push_back(mk(0,0,0,0,0,0,0, 32'h0,      1,0,0,1,1));
      tbl.push_back(mk(0,0,0,0,0,0,0, 32'h4,      1,0,0,1,1));
      tbl.push_back(mk(0,1,0,0,0,0,0, 32'h4,      3,0,0,0,1));
      tbl.push_back(mk(0,0,0,1,32'h3000,0,0, 32'h4, 3,0,0,0,1));
      tbl.push_back(mk(1,0,0,1,32'h3000,0,0, RV,     1,0,0,0,0));
      tbl.push_back(mk(0,0,0,1,32'h3000,0,0, 32'h3000, 1,1,0,1,0));
      tbl.push_back(mk(0,0,0,0,0,0,0, 32'h3004,   1,0,0,1,0));
      tbl.push_back(mk(0,0,1,0,0,1,32'h5000, 32'h5000, 1,0,1,1,0));
      tbl.push_back(mk(0,0,1,0,0,0,0, 32'h5000,   2,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0, 32'h5000,   1,0,0,0,0));
      tbl.push_back(mk(0,0,0,1,32'h6000,0,0, 32'h6000, 1,1,0,1,0));
      tbl.push_back(mk(0,0,0,1,32'h6000,0,0, 32'h6004, 1,0,0,1,0));
      tbl.push_back(mk(0,0,0,0,0,0,0, 32'h6008,   1,0,0,1,0));
      tbl.push_back(mk(0,0,1,0,0,0,0, 32'h6008,   2,0,0,0,0));
      tbl.push_back(mk(0,1,1,0,0,0,0, 32'h6008,   3,0,0,0,0));
      tbl.push_back(mk(1,0,0,0,0,0,0, RV,         1,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0, RV+32'h4,   1,0,0,1,0));

      // Reset values
      #12;
      chk_all(1000, RV, 2'd0, 0, 0, 0, 0);
      @(negedge CLK) RST_n = 1'b1;
      @(posedge CLK); #1;

      foreach (tbl[i]) begin
         start = tbl[i].start; halt = tbl[i].halt; stall = tbl[i].stall;
         jmp_req = tbl[i].jreq; jmp_addr = tbl[i].ja;
         br_req = tbl[i].breq; br_addr = tbl[i].ba;
         @(posedge CLK); #1;
         chk_all(i, tbl[i].pc, tbl[i].st, tbl[i].jack, tbl[i].back, tbl[i].vld, tbl[i].mis);
      end

      // Reset lands in the cycle a jump is being sampled; the jump must be re-accepted.
      start = 0; halt = 0; stall = 0; br_req = 0;
      jmp_req = 1; jmp_addr = 32'h7000;
      #2 RST_n = 1'b0;
      #1 chk_all(2000, RV, 2'd0, 0, 0, 0, 0);
      @(negedge CLK) RST_n = 1'b1;
      @(posedge CLK); #1;
      chk_all(2001, RV, 2'd0, 0, 0, 0, 0);
      start = 1;
      @(posedge CLK); #1;
      chk_all(2002, RV, 2'd1, 0, 0, 0, 0);
      start = 0;
      @(posedge CLK); #1;
      chk_all(2003, 32'h7000, 2'd1, 1, 0, 1, 0);
      jmp_req = 0;
      @(posedge CLK); #1;
      chk_all(2004, 32'h7004, 2'd1, 0, 0, 1, 0);

      // Randomized run against the model
      RST_n = 1'b0;
      start = 0; halt = 0; stall = 0; jmp_req = 0; br_req = 0;
      model_reset();
      @(negedge CLK) RST_n = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         start = (c == 0) || ($urandom_range(0, 39) == 0);
         halt  = ($urandom_range(0, 29) == 0);
         stall = ($urandom_range(0, 3) == 0);
         if (!jmp_req && $urandom_range(0, 3) == 0) begin jmp_req = 1; jmp_addr = rnd_addr(); end
         if (!br_req && $urandom_range(0, 3) == 0) begin br_req = 1; br_addr = rnd_addr(); end
         model_step();
         @(posedge CLK); #1;
         chk_all(10000 + c, m_pc, 2'(m_ph), m_jack, m_back, m_vld, m_mis);
         if (m_jack) jmp_req = 0;
         if (m_back) br_req = 0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Controller for the program-counter register built from the flip-flop stage. It decides every cycle whether the PC holds, increments, or loads a jump or branch target, and arbitrates between the jump and branch requesters over a req/ack handshake. It sits between the fetch-side requesters and the PC register (`pc_reg`) and sequences it through start, run, stall and halt phases.

## Interface
Parameters:
- WIDTH, 32, PC width in bits
- RESET_VEC, 32'h0040_0000, PC value after reset and on every start
- INC, 4, sequential increment; power of two, at least 1

Ports:
- CLK  in  1  clock, rising edge active
- RST_n  in  1  reset, asynchronous, active-low
- start  in  1  level; starts sequencing from RESET_VEC while in IDLE or HALT
- halt  in  1  level; stops sequencing
- stall  in  1  level; PC holds while high in RUN
- jmp_req  in  1  jump request, held until jmp_ack
- jmp_addr  in  WIDTH  jump target, stable while jmp_req is high
- br_req  in  1  branch request, held until br_ack
- br_addr  in  WIDTH  branch target, stable while br_req is high
- jmp_ack  out  1  one-cycle registered pulse: jump accepted
- br_ack  out  1  one-cycle registered pulse: branch accepted
- pc  out  WIDTH  current PC, registered
- pc_valid  out  1  high in RUN when the PC advanced or loaded on the last edge
- state  out  2  current FSM state code
- misalign  out  1  sticky flag: an accepted target was not INC-aligned

## Operation
FSM states: IDLE=0, RUN=1, STALL=2, HALT=3.
- IDLE to RUN when `start` is high: pc <= RESET_VEC.
- In RUN, priority is halt > jump > branch > stall > increment.
  - halt: go to HALT. PC holds and no ack is issued.
  - jmp_req accepted: pc <= jmp_addr with the low log2(INC) bits cleared. jmp_ack pulses on the next cycle.
  - br_req accepted (only if no jump is accepted): pc <= br_addr, aligned the same way. br_ack pulses on the next cycle.
  - stall with no accepted request: go to STALL and hold the PC.
  - otherwise: pc <= pc + INC, wrapping modulo 2^WIDTH.
- In STALL: PC holds and no requests are accepted. halt goes to HALT. When stall drops, return to RUN; requests are evaluated again from that cycle.
- In HALT: PC holds. `start` goes to RUN and sets pc <= RESET_VEC. Pending requests stay pending until they are accepted in RUN.
- A requester whose ack is high in a given cycle is not eligible in that same cycle. This prevents double acceptance while the requester drops its req.
- misalign is set when a target with nonzero low bits is accepted. It is cleared only by reset or by `start`.

## Timing
- Reset (asynchronous): state=IDLE, pc=RESET_VEC, pc_valid=0, jmp_ack=0, br_ack=0, misalign=0.
- Latency is one cycle: a decision sampled at edge N appears on `pc` after edge N. The matching ack is high in the cycle after edge N, for exactly one cycle.
- pc_valid is registered and is high in the cycle after an increment or load while in RUN.
- Simultaneous jmp_req and br_req: jump is accepted first, branch on the following eligible cycle.
- A request arriving together with stall in RUN: the request is accepted and the stall takes effect on the next cycle.
- Reset asserted mid-operation: all outputs return to reset values immediately. Any ack in flight is lost, and requesters must keep req asserted.
- PC = 2^WIDTH − INC followed by an increment gives PC = 0. No flag is raised.

## Structure
- Package `pc_seq_pkg`: state encoding constants and the priority-select encoding (NONE, JMP, BR, INC, HOLD).
- Sub-module `pc_reg`: a WIDTH-bit register with asynchronous active-low reset to RESET_VEC, a load enable and a data input. It is the datapath being sequenced.
- The FSM, arbitration, alignment and ack registers live in `pc_sequencer`.

## Test plan
- Reset, then start; hold for 3 cycles → pc = 0x00400000, 0x00400004, 0x00400008, 0x0040000C; state=1.
- jmp_req and br_req high together in RUN, jmp_addr=0x1000, br_addr=0x2000 → pc=0x1000 and jmp_ack next cycle; pc=0x2000 and br_ack one cycle later; each ack lasts exactly 1 cycle.
- stall held for 3 cycles with no request → pc constant, state=2; after release, increments resume.
- jmp_addr=0x1003 → pc=0x1000 and misalign=1; misalign stays 1 until start.
- pc=0xFFFFFFFC, then increment → pc=0x00000000.
- RST_n pulled low mid-jump, in the cycle before the ack → pc=RESET_VEC, acks 0, state=0; jump re-accepted after start.
